// File: rtl/spawn_scheduler_pkg.sv
// Shared game constants for the spawn path: requester identities, scheduler
// defaults and the scheduler FSM encoding.
package spawn_scheduler_pkg;

  // Requester slots, in arbitration order.
  typedef enum logic [1:0] {
    REQ_SMALL  = 2'd0,
    REQ_MEDIUM = 2'd1,
    REQ_LARGE  = 2'd2,
    REQ_BOMB   = 2'd3
  } requester_e;

  localparam int NUM_REQ_DEF     = 4;
  localparam int REQ_IDX_LEN_DEF = 2;
  localparam int RAND_WIDTH_DEF  = 10;
  localparam int X_LIMIT_DEF     = 400;
  localparam int GAP_CYCLES_DEF  = 8;

  // Wide enough for the largest cooldown load (GAP_CYCLES up to 255).
  localparam int CNT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT    = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_e;

endpackage

// File: rtl/spawn_scheduler_if.sv
// Request/grant bundle between the spawn requesters and the scheduler.
interface spawn_scheduler_if
  import spawn_scheduler_pkg::*;
#(
  parameter int NUM_REQ     = NUM_REQ_DEF,
  parameter int REQ_IDX_LEN = REQ_IDX_LEN_DEF,
  parameter int RAND_WIDTH  = RAND_WIDTH_DEF
);

  logic                   en_i;
  logic [NUM_REQ-1:0]     req_i;
  logic [RAND_WIDTH-1:0]  rand_i;
  logic [NUM_REQ-1:0]     grant_o;
  logic [REQ_IDX_LEN-1:0] grant_idx_o;
  logic [RAND_WIDTH-1:0]  pos_x_o;
  logic                   valid_o;
  logic                   busy_o;

  modport master (
    output en_i, req_i, rand_i,
    input  grant_o, grant_idx_o, pos_x_o, valid_o, busy_o
  );

  modport slave (
    input  en_i, req_i, rand_i,
    output grant_o, grant_idx_o, pos_x_o, valid_o, busy_o
  );

endinterface

// File: rtl/spawn_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above the pointer,
// wrapping from the top requester back to 0.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_LEN = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_LEN-1:0] i_ptr,
  output logic               o_any,
  output logic [IDX_LEN-1:0] o_idx
);

  int                 w_pos;
  logic [IDX_LEN-1:0] w_cand;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    o_any  = 1'b0;
    o_idx  = '0;
    w_pos  = 0;
    w_cand = '0;
    // Walk from farthest to nearest offset; the nearest hit is written last.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_pos = int'(i_ptr) + i;
      if (w_pos >= NUM_REQ) begin
        w_pos = w_pos - NUM_REQ;
      end
      w_cand = IDX_LEN'(w_pos);
      if (i_req[w_cand]) begin
        o_any = 1'b1;
        o_idx = w_cand;
      end
    end
  end

endmodule

// File: rtl/spawn_scheduler.sv
// Spawn scheduler: grants one requester at a time in round-robin order,
// attaches a folded X position and enforces a cooldown between grants.
module spawn_scheduler
  import spawn_scheduler_pkg::*;
#(
  parameter int NUM_REQ     = NUM_REQ_DEF,
  parameter int REQ_IDX_LEN = REQ_IDX_LEN_DEF,
  parameter int RAND_WIDTH  = RAND_WIDTH_DEF,
  parameter int X_LIMIT     = X_LIMIT_DEF,
  parameter int GAP_CYCLES  = GAP_CYCLES_DEF
) (
  input  logic               clk_run,
  input  logic               rst_n,
  spawn_scheduler_if.slave   bus
);

  localparam logic [RAND_WIDTH-1:0]  X_LIM    = RAND_WIDTH'(X_LIMIT);
  localparam logic [RAND_WIDTH-1:0]  POS_MAX  = RAND_WIDTH'(X_LIMIT - 1);
  localparam logic [REQ_IDX_LEN-1:0] IDX_LAST = REQ_IDX_LEN'(NUM_REQ - 1);
  localparam logic [CNT_WIDTH-1:0]   CNT_LOAD = CNT_WIDTH'(GAP_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]   CNT_ONE  = CNT_WIDTH'(1);

  state_e                 r_state;
  state_e                 w_state_next;
  logic [REQ_IDX_LEN-1:0] r_ptr;
  logic [REQ_IDX_LEN-1:0] r_idx;
  logic [REQ_IDX_LEN-1:0] w_win_idx;
  logic [REQ_IDX_LEN-1:0] w_ptr_next;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [CNT_WIDTH-1:0]   w_cnt_next;
  logic [RAND_WIDTH-1:0]  r_pos;
  logic [RAND_WIDTH-1:0]  w_pos;
  logic [RAND_WIDTH-1:0]  w_pos_sub;
  logic [NUM_REQ-1:0]     r_grant;
  logic [NUM_REQ-1:0]     w_grant_next;
  logic                   r_valid;
  logic                   w_any;
  logic                   w_take;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_LEN (REQ_IDX_LEN)
  ) u_rr_arbiter (
    .i_req (bus.req_i),
    .i_ptr (r_ptr),
    .o_any (w_any),
    .o_idx (w_win_idx)
  );

  // Fold the random value into [0, X_LIMIT): one subtraction, then clamp.
  always_comb begin
    w_pos_sub = bus.rand_i - X_LIM;
    if (bus.rand_i < X_LIM) begin
      w_pos = bus.rand_i;
    end else if (w_pos_sub < X_LIM) begin
      w_pos = w_pos_sub;
    end else begin
      w_pos = POS_MAX;
    end
  end

  always_comb begin
    w_grant_next = NUM_REQ'(1) << w_win_idx;
    w_ptr_next   = (w_win_idx == IDX_LAST) ? '0 : w_win_idx + REQ_IDX_LEN'(1);
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_take       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.en_i && w_any) begin
          w_state_next = ST_GRANT;
          w_take       = 1'b1;
        end
      end
      ST_GRANT: begin
        w_state_next = ST_COOLDOWN;
        w_cnt_next   = CNT_LOAD;
      end
      ST_COOLDOWN: begin
        // Leave as the counter reaches zero, so grants under constant
        // demand land GAP_CYCLES+1 cycles apart.
        if (bus.en_i) begin
          if (r_cnt <= CNT_ONE) begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next   = r_cnt - CNT_ONE;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_run or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_pos   <= '0;
      r_grant <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_valid <= w_take;
      r_grant <= w_take ? w_grant_next : '0;
      // Winner and position are captured once; they hold until the next grant.
      if (w_take) begin
        r_idx <= w_win_idx;
        r_pos <= w_pos;
        r_ptr <= w_ptr_next;
      end
    end
  end

  assign bus.grant_o     = r_grant;
  assign bus.grant_idx_o = r_idx;
  assign bus.pos_x_o     = r_pos;
  assign bus.valid_o     = r_valid;
  assign bus.busy_o      = (r_state != ST_IDLE);

  a_valid_onehot : assert property (
    @(posedge clk_run) disable iff (!rst_n) bus.valid_o |-> $onehot(bus.grant_o)
  );

  a_valid_in_grant : assert property (
    @(posedge clk_run) disable iff (!rst_n) bus.valid_o == (r_state == ST_GRANT)
  );

endmodule
